// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard controller.
package hazard_pkg;

   localparam int unsigned REG_AW_DEF = 5;

   typedef logic [REG_AW_DEF-1:0] reg_addr_t;

   // Register 0 is hardwired to zero and never creates a dependency.
   localparam reg_addr_t ZERO_REG = '0;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } haz_state_t;

   // One in-flight load slot: field is 'addr' because 'reg' is a keyword.
   typedef struct packed {
      logic      valid;
      reg_addr_t addr;
   } sb_entry_t;

endpackage

// File: rtl/load_scoreboard.sv
// Load scoreboard: slot 0 is the live EX stage, slots 1..LOAD_LAT-1 are a
// shift register of loads that have left EX but whose data is not yet
// forwardable. Produces a per-source-operand match vector.
module load_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_SRC*REG_AW-1:0] src_i,
   input  logic [NUM_SRC-1:0]        src_used_i,
   input  logic [REG_AW-1:0]         dst_ex_i,
   input  logic                      mem_read_ex_i,
   input  logic                      valid_ex_i,
   output logic [NUM_SRC-1:0]        match_o
);

   logic                 slot0_valid;
   logic [NUM_SRC-1:0]   sb_hit;

   // A load in EX writing r0 is treated as no load at all.
   assign slot0_valid = mem_read_ex_i & valid_ex_i & (dst_ex_i != REG_AW'(ZERO_REG));

   if (LOAD_LAT > 1) begin : g_sb
      localparam int unsigned NumSlots = LOAD_LAT - 1;

      logic              valid_q [1:NumSlots];
      logic [REG_AW-1:0] addr_q  [1:NumSlots];

      // Shift slots every cycle, including while the front end is stalled.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int k = 1; k <= NumSlots; k++) begin
               valid_q[k] <= 1'b0;
               addr_q[k]  <= '0;
            end
         end else begin
            valid_q[1] <= slot0_valid;
            addr_q[1]  <= dst_ex_i;
            for (int k = 1; k < NumSlots; k++) begin
               valid_q[k+1] <= valid_q[k];
               addr_q[k+1]  <= addr_q[k];
            end
         end
      end

      // Compare every registered slot against every source operand.
      always_comb begin
         sb_hit = '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= NumSlots; k++) begin
               if (valid_q[k] && (addr_q[k] == src_i[i*REG_AW +: REG_AW])) begin
                  sb_hit[i] = 1'b1;
               end
            end
         end
      end
   end else begin : g_no_sb
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign sb_hit = '0;
   end

   // Per-operand match: operand must be read and non-zero.
   always_comb begin : p_match
      logic [REG_AW-1:0] src;
      match_o = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src = src_i[i*REG_AW +: REG_AW];
         match_o[i] = src_used_i[i] & (src != REG_AW'(ZERO_REG)) &
                      ((slot0_valid & (dst_ex_i == src)) | sb_hit[i]);
      end
   end

endmodule

// File: rtl/load_hazard_ctrl.sv
// Load-use hazard/stall controller. Holds PC and IF/ID and bubbles ID/EX in
// the same cycle a decode operand depends on an unfinished load. Tracks the
// stall episode, its length and a sticky overlong-stall error.
// Optional: define HAZ_STALL_STATS_EN to build the Stall_Total and
// Stall_Episodes counters; otherwise those ports are tied to zero.
module load_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] Src_D,
   input  logic [NUM_SRC-1:0]        Src_Used_D,
   input  logic                      Valid_D,
   input  logic [REG_AW-1:0]         Dst_Ex,
   input  logic                      MemRead_Ex,
   input  logic                      Valid_Ex,
   input  logic                      Flush,
   output logic                      PC_hold,
   output logic                      Instruction_hold,
   output logic                      Stall_Control,
   output logic [CNT_W-1:0]          Stall_Len,
   output logic                      Haz_Err,
   output logic [31:0]               Stall_Total,
   output logic [31:0]               Stall_Episodes
);

   localparam logic [CNT_W-1:0] LenMax = '1;

   logic [NUM_SRC-1:0] match;
   logic               hazard;
   haz_state_t         state_q, state_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               err_q, err_d;

   load_scoreboard #(
      .REG_AW   (REG_AW),
      .NUM_SRC  (NUM_SRC),
      .LOAD_LAT (LOAD_LAT)
   ) u_sb (
      .clk_i         (clk),
      .rst_i         (rst),
      .src_i         (Src_D),
      .src_used_i    (Src_Used_D),
      .dst_ex_i      (Dst_Ex),
      .mem_read_ex_i (MemRead_Ex),
      .valid_ex_i    (Valid_Ex),
      .match_o       (match)
   );

   // Zero-latency hazard; a squashed or reset decode slot never stalls.
   assign hazard           = Valid_D & ~Flush & ~rst & (|match);
   assign PC_hold          = hazard;
   assign Instruction_hold = hazard;
   assign Stall_Control    = hazard;
   assign Stall_Len        = len_q;
   assign Haz_Err          = err_q;

   // Episode FSM next state, saturating length counter and sticky error.
   always_comb begin
      state_d = state_q;
      len_d   = '0;
      err_d   = err_q;
      unique case (state_q)
         RUN: begin
            if (hazard) begin
               state_d = STALL;
               len_d   = CNT_W'(1);
            end
         end
         STALL: begin
            if (hazard) begin
               len_d = (len_q == LenMax) ? len_q : len_q + 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      // Another stalled cycle would push the episode beyond LOAD_LAT.
      if (hazard && (32'(len_q) >= LOAD_LAT)) begin
         err_d = 1'b1;
      end
   end

   // Episode state, length and error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

`ifdef HAZ_STALL_STATS_EN
   logic [31:0] total_q, episodes_q;

   // Free-running statistics, wrapping at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total_q    <= '0;
         episodes_q <= '0;
      end else begin
         if (hazard) begin
            total_q <= total_q + 32'd1;
         end
         if (hazard && (state_q == RUN)) begin
            episodes_q <= episodes_q + 32'd1;
         end
      end
   end

   assign Stall_Total    = total_q;
   assign Stall_Episodes = episodes_q;
`else
   assign Stall_Total    = '0;
   assign Stall_Episodes = '0;
`endif

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Bench: two controllers (LOAD_LAT=1 and LOAD_LAT=3) on shared stimulus.
module tb_load_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] src0, src1;
   logic [9:0] src_d;
   logic [1:0] used;
   logic       valid_d, mem_read, valid_ex, flush;
   logic [4:0] dst_ex;

   logic        pc1, ih1, sc1, err1;
   logic [3:0]  len1;
   logic [31:0] tot1, epi1;
   logic        pc3, ih3, sc3, err3;
   logic [3:0]  len3;
   logic [31:0] tot3, epi3;

   int checks = 0;
   int errors = 0;

   assign src_d = {src1, src0};

   always #5 clk = ~clk;

   load_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .Src_D(src_d), .Src_Used_D(used), .Valid_D(valid_d),
      .Dst_Ex(dst_ex), .MemRead_Ex(mem_read), .Valid_Ex(valid_ex), .Flush(flush),
      .PC_hold(pc1), .Instruction_hold(ih1), .Stall_Control(sc1), .Stall_Len(len1),
      .Haz_Err(err1), .Stall_Total(tot1), .Stall_Episodes(epi1)
   );

   load_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .Src_D(src_d), .Src_Used_D(used), .Valid_D(valid_d),
      .Dst_Ex(dst_ex), .MemRead_Ex(mem_read), .Valid_Ex(valid_ex), .Flush(flush),
      .PC_hold(pc3), .Instruction_hold(ih3), .Stall_Control(sc3), .Stall_Len(len3),
      .Haz_Err(err3), .Stall_Total(tot3), .Stall_Episodes(epi3)
   );

   typedef struct {
      logic [4:0] s0;
      logic [4:0] s1;
      logic [1:0] used;
      logic       vd;
      logic [4:0] dst;
      logic       mr;
      logic       ve;
      logic       fl;
      logic       exp_hold;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; leave time just after the edge for driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                        input logic vd, input logic [4:0] dst, input logic mr,
                        input logic ve, input logic fl);
      src0 = s0; src1 = s1; used = u; valid_d = vd;
      dst_ex = dst; mem_read = mr; valid_ex = ve; flush = fl;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);

      // Matching inputs while in reset: outputs forced low, state cleared.
      chk("rst_hold1", {31'd0, pc1}, 32'd0);
      chk("rst_hold3", {31'd0, pc3}, 32'd0);
      chk("rst_len1", {28'd0, len1}, 32'd0);
      chk("rst_err1", {31'd0, err1}, 32'd0);
      chk("rst_tot1", tot1, 32'd0);
      chk("rst_epi1", epi1, 32'd0);

      // s0 s1 used vd dst mr ve fl exp
      vecs[0]  = '{5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{5'd0, 5'd8, 2'b10, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{5'd8, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{5'd0, 5'd0, 2'b01, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{5'd8, 5'd0, 2'b01, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{5'd7, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{5'd3, 5'd8, 2'b11, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{5'd8, 5'd9, 2'b10, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0};

      // Combinational vectors, each from a clean reset (empty scoreboard).
      for (int v = 0; v < 11; v++) begin
         do_reset();
         drive(vecs[v].s0, vecs[v].s1, vecs[v].used, vecs[v].vd, vecs[v].dst,
               vecs[v].mr, vecs[v].ve, vecs[v].fl);
         chk($sformatf("vec%0d_pc1", v), {31'd0, pc1}, {31'd0, vecs[v].exp_hold});
         chk($sformatf("vec%0d_ih1", v), {31'd0, ih1}, {31'd0, vecs[v].exp_hold});
         chk($sformatf("vec%0d_sc1", v), {31'd0, sc1}, {31'd0, vecs[v].exp_hold});
         chk($sformatf("vec%0d_pc3", v), {31'd0, pc3}, {31'd0, vecs[v].exp_hold});
      end

      // LOAD_LAT=1: lw $8 then consumer; one-cycle stall, length 1 then 0.
      do_reset();
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      chk("ll1_hold_c0", {31'd0, pc1}, 32'd1);
      chk("ll1_len_c0", {28'd0, len1}, 32'd0);
      step();
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("ll1_hold_c1", {31'd0, pc1}, 32'd0);
      chk("ll1_len_c1", {28'd0, len1}, 32'd1);
      step();
      chk("ll1_len_c2", {28'd0, len1}, 32'd0);
      chk("ll1_err", {31'd0, err1}, 32'd0);

      // LOAD_LAT=3: lw $5, consumer on Src1 held three cycles.
      do_reset();
      drive(5'd0, 5'd5, 2'b10, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      chk("ll3_hold_c0", {31'd0, sc3}, 32'd1);
      for (int c = 1; c <= 4; c++) begin
         step();
         drive(5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("ll3_hold_c%0d", c), {31'd0, sc3}, (c < 3) ? 32'd1 : 32'd0);
         chk($sformatf("ll3_len_c%0d", c), {28'd0, len3}, (c < 4) ? c : 32'd0);
         chk($sformatf("ll3_err_c%0d", c), {31'd0, err3}, 32'd0);
      end

      // Flush coincident with match; load still tracked in sb[1] afterwards.
      do_reset();
      drive(5'd6, 5'd0, 2'b01, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1);
      chk("fl_hold1_c0", {31'd0, pc1}, 32'd0);
      chk("fl_hold3_c0", {31'd0, pc3}, 32'd0);
      step();
      drive(5'd6, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("fl_hold3_c1", {31'd0, pc3}, 32'd1);
      chk("fl_hold1_c1", {31'd0, pc1}, 32'd0);

      // Reset pulsed in the middle of a three-cycle stall.
      do_reset();
      drive(5'd0, 5'd5, 2'b10, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(5'd0, 5'd5, 2'b10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("mr_hold_pre", {31'd0, ih3}, 32'd1);
      chk("mr_len_pre", {28'd0, len3}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mr_hold_in", {31'd0, ih3}, 32'd0);
      chk("mr_len_in", {28'd0, len3}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mr_hold_post", {31'd0, ih3}, 32'd0);
      step();
      chk("mr_hold_next", {31'd0, ih3}, 32'd0);
      chk("mr_len_next", {28'd0, len3}, 32'd0);

      // Two separate 2-cycle stalls on LOAD_LAT=1; also trips sticky error.
      do_reset();
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      step();
      chk("st_hold_c1", {31'd0, pc1}, 32'd1);
      chk("st_len_c1", {28'd0, len1}, 32'd1);
      step();
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("st_err_c2", {31'd0, err1}, 32'd1);
      chk("st_len_c2", {28'd0, len1}, 32'd2);
      step();
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      step();
      step();
      drive(5'd8, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk("st_err_end", {31'd0, err1}, 32'd1);
      chk("st_len_end", {28'd0, len1}, 32'd0);
`ifdef HAZ_STALL_STATS_EN
      chk("st_total", tot1, 32'd4);
      chk("st_episodes", epi1, 32'd2);
`else
      chk("st_total", tot1, 32'd0);
      chk("st_episodes", epi1, 32'd0);
`endif
      do_reset();
      chk("st_err_cleared", {31'd0, err1}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
